muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage. Runs beside the single-cycle ALU.
//  Its registered result feeds a spare input of the EX result-select mux_4to1.
//  The hazard unit stalls the pipeline while busy=1.

---
 rtl/muldiv_pkg.sv | 51 +++++
 rtl/mux_4to1.sv | 23 ++
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and helpers for the iterative RV32M multiply/divide unit.
// LATENCY is also consumed by the hazard unit and the bench.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEL_LO  = 2'd0,
        SEL_HI  = 2'd1,
        SEL_QUO = 2'd2,
        SEL_REM = 2'd3
    } rsel_e;

    localparam int DATAWIDTH_DEF = 32;
    // Cycles from the start edge to the edge after which done is high.
    localparam int LATENCY = DATAWIDTH_DEF + 2;

    function automatic logic signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic rsel_e result_sel(input logic [2:0] f3);
        rsel_e sel;
        case (f3)
            F3_MUL:                        sel = SEL_LO;
            F3_MULH, F3_MULHSU, F3_MULHU:  sel = SEL_HI;
            F3_DIV, F3_DIVU:               sel = SEL_QUO;
            default:                       sel = SEL_REM;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mux_4to1.sv
// Generic 4-input result select; used for the final multiply/divide output pick.
module mux_4to1 #(
    parameter int W = 32
) (
    input  logic [1:0]   sel_i,
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    input  logic [W-1:0] d3_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = d0_i;
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with fixed latency and flush.
//   state  | meaning
//   IDLE   | waiting for start; captures op, magnitudes and sign/special flags
//   CALC   | one shift-add or shift-subtract step per cycle, DATAWIDTH steps
//   FIN    | sign correction, special-case substitution, result registered
//   DONE   | done pulse for one cycle
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [2:0]           funct3_i,
    input  logic [DATAWIDTH-1:0] operand_a_i,
    input  logic [DATAWIDTH-1:0] operand_b_i,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DATAWIDTH-1:0] result_o
);

    localparam int W    = DATAWIDTH;
    localparam int CNTW = $clog2(DATAWIDTH);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    a_q, a_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic [W-1:0]    result_q, result_d;

    logic [W-1:0]    a_neg, b_neg;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      div_up, div_diff;
    logic [2*W-1:0]  div_next;
    logic [2*W-1:0]  prod_neg, prod_c;
    logic [W-1:0]    quo_raw, rem_raw, quo_neg, rem_neg, quo_c, rem_c;
    logic [W-1:0]    fin_res;
    rsel_e           sel;

    assign a_neg = -operand_a_i;
    assign b_neg = -operand_b_i;

    // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, b_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};

    assign div_up   = acc_q[2*W-2:W-1];
    assign div_diff = div_up - {1'b0, b_q};
    assign div_next = div_diff[W] ? {acc_q[2*W-2:W-1], acc_q[W-2:0], 1'b0}
                                  : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

    assign prod_neg = -acc_q;
    assign prod_c   = (neg_a_q ^ neg_b_q) ? prod_neg : acc_q;

    assign quo_raw = acc_q[W-1:0];
    assign rem_raw = acc_q[2*W-1:W];
    assign quo_neg = -quo_raw;
    assign rem_neg = -rem_raw;

    // Special cases override whatever the datapath iterated to.
    always_comb begin
        quo_c = (neg_a_q ^ neg_b_q) ? quo_neg : quo_raw;
        rem_c = neg_a_q ? rem_neg : rem_raw;
        if (div0_q) begin
            quo_c = '1;
            rem_c = a_q;
        end else if (ovf_q) begin
            quo_c = MIN_NEG;
            rem_c = '0;
        end
    end

    assign sel = result_sel(f3_q);

    mux_4to1 #(.W(W)) u_result_mux (
        .sel_i (sel),
        .d0_i  (prod_c[W-1:0]),
        .d1_i  (prod_c[2*W-1:W]),
        .d2_i  (quo_c),
        .d3_i  (rem_c),
        .y_o   (fin_res)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        acc_d    = acc_q;
        b_d      = b_q;
        a_d      = a_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        f3_d    = funct3_i;
                        a_d     = operand_a_i;
                        neg_a_d = signed_a(funct3_i) & operand_a_i[W-1];
                        neg_b_d = signed_b(funct3_i) & operand_b_i[W-1];
                        acc_d   = {{W{1'b0}}, (neg_a_d ? a_neg : operand_a_i)};
                        b_d     = neg_b_d ? b_neg : operand_b_i;
                        div0_d  = funct3_i[2] && (operand_b_i == '0);
                        ovf_d   = funct3_i[2] && !funct3_i[0]
                                  && (operand_a_i == MIN_NEG) && (operand_b_i == '1);
                        cnt_d   = CNTW'(W - 1);
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    acc_d = f3_q[2] ? div_next : mul_next;
                    if (cnt_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                S_FIN: begin
                    result_d = fin_res;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            a_q      <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            a_q      <= a_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    // A flush arriving in the DONE cycle still suppresses the pulse.
    assign done_o   = (state_q == S_DONE) && !flush_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus start-while-busy, flush and reset sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail = 0;

    muldiv_unit #(.DATAWIDTH(32)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .funct3_i    (funct3),
        .operand_a_i (op_a),
        .operand_b_i (op_b),
        .flush_i     (flush),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Start edge is the edge just before start rises; lat counts edges after it.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(posedge clk); #1;
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
    endtask

    initial begin
        logic [31:0] res;
        int lat;
        int ndone;
        int first_done;
        logic [31:0] held;

        vecs[0]  = '{F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3"};
        vecs[1]  = '{F3_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_min"};
        vecs[2]  = '{F3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mulhsu_min"};
        vecs[3]  = '{F3_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, "mulhu_min"};
        vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_-7/2"};
        vecs[5]  = '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_-7%2"};
        vecs[6]  = '{F3_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, "divu_big/2"};
        vecs[7]  = '{F3_DIV,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "div_5/0"};
        vecs[8]  = '{F3_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "remu_5%0"};
        vecs[9]  = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"};
        vecs[10] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf"};
        vecs[11] = '{F3_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, "mul_shift"};
        vecs[12] = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"};
        vecs[13] = '{F3_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "mulh_7x-3"};
        vecs[14] = '{F3_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7/-2"};
        vecs[15] = '{F3_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, "rem_7%-2"};
        vecs[16] = '{F3_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, "remu_100%7"};
        vecs[17] = '{F3_DIV,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, "div_-5/0"};
        vecs[18] = '{F3_REM,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, "rem_-5%0"};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat);
            chk({vecs[i].name, "_result"}, res, vecs[i].exp);
            chk({vecs[i].name, "_latency"}, lat, LATENCY);
        end

        // start pulsed while busy must be ignored; exactly one done at LATENCY
        @(posedge clk); #1;
        start = 1'b1; funct3 = F3_MUL; op_a = 32'h0000_0007; op_b = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; first_done = 0;
        for (int k = 1; k <= LATENCY; k++) begin
            if (k == 10) begin
                start = 1'b1; funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7;
            end
            if (k == 11) start = 1'b0;
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = k;
            end
            if (k < LATENCY) begin
                @(posedge clk); #1;
            end
        end
        chk("busy_start_ndone", ndone, 32'd1);
        chk("busy_start_done_cycle", first_done, LATENCY);
        chk("busy_start_result", result, 32'hFFFF_FFEB);
        // back-to-back: start in the first IDLE cycle after done
        run_op(F3_DIVU, 32'd100, 32'd7, res, lat);
        chk("b2b_result", res, 32'd14);
        chk("b2b_latency", lat, LATENCY);
        held = res;

        // flush mid-operation: no done, result untouched
        @(posedge clk); #1;
        start = 1'b1; funct3 = F3_MUL; op_a = 32'd3; op_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 15; k++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        chk("flush_ndone", ndone, 32'd0);
        chk("flush_result_held", result, held);

        // flush and start together in IDLE: flush wins
        start = 1'b1; flush = 1'b1; funct3 = F3_MUL; op_a = 32'd3; op_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'b0, busy}, 32'd0);

        // synchronous reset mid-operation
        @(posedge clk); #1;
        start = 1'b1; funct3 = F3_MULHU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        chk("rst_ndone", ndone, 32'd0);

        run_op(F3_MUL, 32'd3, 32'd5, res, lat);
        chk("post_rst_result", res, 32'd15);
        chk("post_rst_latency", lat, LATENCY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
